vit_ber_monitor: RTL and testbench

Synthesizable, parametrised bit-error-rate monitor for the Viterbi encode/channel/decode chain. It captures the original encoder input bits into a circular history buffer and skips a programmable number of decoder-pipeline fill samples. It then compares each decoder output bit against the oldest stored input bit and keeps good/bad/total scoreboard counters. It sits beside the tx/rx top level and replaces bench-only history arrays and fixed-time alignment delays with an in-hardware, depth- and latency-configurable checker.

---
 rtl/vit_ber_pkg.sv | 27 ++
 rtl/vit_ber_monitor_if.sv | 41 ++++
 rtl/vit_hist_fifo.sv | 62 ++++++
 rtl/vit_ber_monitor.sv | 163 ++++++++++++++++
 tb/tb_vit_ber_monitor.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vit_ber_pkg.sv
// +----------------------------------------------------------------------------+
// | vit_ber_pkg : state encoding and helpers shared by the BER monitor files     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package vit_ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2,
        ST_LOST = 2'd3
    } vit_ber_state_t;

    localparam logic [1:0] c_st_idle = ST_IDLE;
    localparam logic [1:0] c_st_skip = ST_SKIP;
    localparam logic [1:0] c_st_run  = ST_RUN;
    localparam logic [1:0] c_st_lost = ST_LOST;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vit_ber_monitor_if.sv
// +----------------------------------------------------------------------------+
// | vit_ber_monitor_if : control, data and scoreboard bundle of the BER monitor  |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vit_ber_monitor_if #(
    parameter int CNT_W  = 32,
    parameter int SKIP_W = 16
);
    logic              start_i;
    logic              clear_i;
    logic [SKIP_W-1:0] skip_i;
    logic              ref_valid_i;
    logic              ref_i;
    logic              dut_valid_i;
    logic              dut_i;
    logic [CNT_W-1:0]  good_o;
    logic [CNT_W-1:0]  bad_o;
    logic [CNT_W-1:0]  total_o;
    logic [CNT_W-1:0]  first_bad_o;
    logic              first_bad_vld_o;
    logic [1:0]        state_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              sync_lost_o;

    modport master (
        output start_i, clear_i, skip_i, ref_valid_i, ref_i, dut_valid_i, dut_i,
        input  good_o, bad_o, total_o, first_bad_o, first_bad_vld_o, state_o,
               overflow_o, underflow_o, sync_lost_o
    );

    modport slave (
        input  start_i, clear_i, skip_i, ref_valid_i, ref_i, dut_valid_i, dut_i,
        output good_o, bad_o, total_o, first_bad_o, first_bad_vld_o, state_o,
               overflow_o, underflow_o, sync_lost_o
    );
endinterface

`default_nettype wire

// File: rtl/vit_hist_fifo.sv
// +----------------------------------------------------------------------------+
// | vit_hist_fifo : single-bit circular history buffer, combinational head read  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module vit_hist_fifo #(
    parameter int DEPTH = 2048,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clr,
    input  wire logic        push,
    input  wire logic        pop,
    input  wire logic        din,
    output logic             head,
    output logic [AW:0]      fill
);
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    logic          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_full    = (r_fill == c_depth);
    assign w_empty   = (r_fill == '0);
    assign w_pop_ok  = pop && !w_empty;
    // A full buffer still accepts a push when the same cycle frees a slot.
    assign w_push_ok = push && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_fill <= r_fill + (AW + 1)'(1);
                2'b01:   r_fill <= r_fill - (AW + 1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign head = r_mem[r_rd_ptr];
    assign fill = r_fill;

endmodule

`default_nettype wire

// File: rtl/vit_ber_monitor.sv
// +----------------------------------------------------------------------------+
// | vit_ber_monitor : Viterbi chain BER scoreboard with skip and history buffer  |
// | Optional sync-loss window logic built when VIT_BER_WINDOW_EN is defined.     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module vit_ber_monitor
    import vit_ber_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int CNT_W   = 32,
    parameter int SKIP_W  = 16,
    parameter int WIN     = 64,
    parameter int LOSS_TH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vit_ber_monitor_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 4 || WIN < 1 || LOSS_TH < 1) begin : g_bad_cfg
        $error("vit_ber_monitor: invalid DEPTH/WIN/LOSS_TH");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0]  r_good;
    logic [CNT_W-1:0]  r_bad;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_first_bad;
    logic              r_first_bad_vld;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push_req;
    logic              w_pop_req;
    logic              w_pop;
    logic              w_head;
    logic              w_match;
    logic              w_full;
    logic              w_empty;
    logic              w_loss;
    logic [AW:0]       w_fill;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_push_req = ((r_state == c_st_skip) || (r_state == c_st_run)) && bus.ref_valid_i;
    assign w_pop_req  = (r_state == c_st_run) && bus.dut_valid_i;
    assign w_full     = (w_fill == c_depth);
    assign w_empty    = (w_fill == '0);
    assign w_pop      = w_pop_req && !w_empty;
    assign w_match    = (w_head == bus.dut_i);

    vit_hist_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.clear_i),
        .push (w_push_req),
        .pop  (w_pop_req),
        .din  (bus.ref_i),
        .head (w_head),
        .fill (w_fill)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (bus.start_i)
                           w_state_nxt = (bus.skip_i == '0) ? c_st_run : c_st_skip;
            c_st_skip: if (bus.dut_valid_i && (r_skip_cnt == SKIP_W'(1)))
                           w_state_nxt = c_st_run;
            c_st_run:  if (w_loss) w_state_nxt = c_st_lost;
            default:   w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.clear_i) begin
            r_state         <= c_st_idle;
            r_skip_cnt      <= '0;
            r_good          <= '0;
            r_bad           <= '0;
            r_total         <= '0;
            r_first_bad     <= '0;
            r_first_bad_vld <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_st_idle) && bus.start_i)
                r_skip_cnt <= bus.skip_i;
            else if ((r_state == c_st_skip) && bus.dut_valid_i)
                r_skip_cnt <= r_skip_cnt - SKIP_W'(1);

            if (w_pop) begin
                if (w_match) r_good <= sat_inc(r_good);
                else         r_bad  <= sat_inc(r_bad);
                r_total <= sat_inc(r_total);
                // Index of the first failing compare, counted from zero.
                if (!w_match && !r_first_bad_vld) begin
                    r_first_bad     <= r_total;
                    r_first_bad_vld <= 1'b1;
                end
            end

            if (w_push_req && w_full && !w_pop_req) r_overflow  <= 1'b1;
            if (w_pop_req && w_empty)               r_underflow <= 1'b1;
        end
    end

`ifdef VIT_BER_WINDOW_EN
    localparam int               WIN_W      = $clog2(WIN + 1);
    localparam int               TH_W       = $clog2(LOSS_TH + 1);
    localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WIN - 1);
    localparam logic [TH_W-1:0]  c_th_last  = TH_W'(LOSS_TH - 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic [TH_W-1:0]  r_win_bad;
    logic             r_sync_lost;

    assign w_loss = w_pop && !w_match && (r_win_bad == c_th_last);

    always_ff @(posedge clk) begin
        if (!rst || bus.clear_i) begin
            r_win_cnt   <= '0;
            r_win_bad   <= '0;
            r_sync_lost <= 1'b0;
        end else if (w_pop) begin
            if (w_loss) r_sync_lost <= 1'b1;
            if (r_win_cnt == c_win_last) begin
                r_win_cnt <= '0;
                r_win_bad <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                if (!w_match) r_win_bad <= r_win_bad + TH_W'(1);
            end
        end
    end

    assign bus.sync_lost_o = r_sync_lost;
`else
    assign w_loss          = 1'b0;
    assign bus.sync_lost_o = 1'b0;
`endif

    assign bus.good_o          = r_good;
    assign bus.bad_o           = r_bad;
    assign bus.total_o         = r_total;
    assign bus.first_bad_o     = r_first_bad;
    assign bus.first_bad_vld_o = r_first_bad_vld;
    assign bus.state_o         = r_state;
    assign bus.overflow_o      = r_overflow;
    assign bus.underflow_o     = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_vit_ber_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_vit_ber_monitor : self-checking bench for vit_ber_monitor (DEPTH=8)       |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vit_ber_monitor;
    import vit_ber_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 32;
    localparam int SKIP_W  = 16;
    localparam int WIN     = 64;
    localparam int LOSS_TH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vit_ber_monitor_if #(.CNT_W(CNT_W), .SKIP_W(SKIP_W)) bus ();

    vit_ber_monitor #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .SKIP_W(SKIP_W), .WIN(WIN), .LOSS_TH(LOSS_TH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  state;
        logic [31:0] good, bad, total, fb;
        logic        fbv, ovf, unf, lost;
    } exp_t;

    typedef struct {
        logic        st, cl;
        logic [15:0] sk;
        logic        rv, r, dv, d;
        logic [1:0]  state;
        int unsigned good, bad, total, fb;
        logic        fbv, ovf, unf;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          m_state;
    int          m_skip;
    bit          m_hist[$];
    int unsigned m_good, m_bad, m_total, m_fb;
    bit          m_fbv, m_ovf, m_unf, m_lost;
    int          m_wcnt, m_wbad;

    function automatic void mdl_reset();
        m_state = 0; m_skip = 0; m_hist.delete();
        m_good = 0; m_bad = 0; m_total = 0; m_fb = 0;
        m_fbv = 0; m_ovf = 0; m_unf = 0; m_lost = 0;
        m_wcnt = 0; m_wbad = 0;
    endfunction

    function automatic void mdl_apply(input bit st, cl, input int sk, input bit rv, r, dv, d);
        bit popped, hv;
        popped = 0; hv = 0;
        if (cl) begin
            mdl_reset();
            return;
        end
        case (m_state)
            0: if (st) begin
                   if (sk == 0) m_state = 2;
                   else begin m_state = 1; m_skip = sk; end
               end
            1: begin
                   if (rv) begin
                       if (m_hist.size() == DEPTH) m_ovf = 1; else m_hist.push_back(r);
                   end
                   if (dv) begin
                       m_skip--;
                       if (m_skip == 0) m_state = 2;
                   end
               end
            2: begin
                   if (dv) begin
                       if (m_hist.size() == 0) m_unf = 1;
                       else begin hv = m_hist.pop_front(); popped = 1; end
                   end
                   if (rv) begin
                       if (m_hist.size() == DEPTH) m_ovf = 1; else m_hist.push_back(r);
                   end
                   if (popped) begin
                       if (hv == d) m_good++;
                       else begin
                           if (!m_fbv) begin m_fb = m_total; m_fbv = 1; end
                           m_bad++;
                       end
                       m_total++;
`ifdef VIT_BER_WINDOW_EN
                       m_wcnt++;
                       if (hv != d) m_wbad++;
                       if (m_wbad == LOSS_TH) begin m_lost = 1; m_state = 3; end
                       if (m_wcnt == WIN) begin m_wcnt = 0; m_wbad = 0; end
`endif
                   end
               end
            default: ;
        endcase
    endfunction

    function automatic exp_t mdl_snap(input string tag);
        exp_t e;
        e.tag = tag; e.state = 2'(m_state);
        e.good = m_good; e.bad = m_bad; e.total = m_total; e.fb = m_fb;
        e.fbv = m_fbv; e.ovf = m_ovf; e.unf = m_unf; e.lost = m_lost;
        return e;
    endfunction

    task automatic drive(input logic st, cl, input logic [15:0] sk, input logic rv, r, dv, d);
        @(negedge clk);
        bus.start_i = st; bus.clear_i = cl; bus.skip_i = sk;
        bus.ref_valid_i = rv; bus.ref_i = r; bus.dut_valid_i = dv; bus.dut_i = d;
    endtask

    task automatic step(input logic st, cl, input logic [15:0] sk, input logic rv, r, dv, d,
                        input string tag);
        drive(st, cl, sk, rv, r, dv, d);
        mdl_apply(st, cl, int'(sk), rv, r, dv, d);
        exp_q.push_back(mdl_snap(tag));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: one expected snapshot per driven cycle, compared after the edge.
    exp_t e_cur;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            n_cmp++;
            if (bus.state_o !== e_cur.state || bus.good_o !== e_cur.good ||
                bus.bad_o !== e_cur.bad || bus.total_o !== e_cur.total ||
                bus.first_bad_vld_o !== e_cur.fbv ||
                (e_cur.fbv && bus.first_bad_o !== e_cur.fb) ||
                bus.overflow_o !== e_cur.ovf || bus.underflow_o !== e_cur.unf ||
                bus.sync_lost_o !== e_cur.lost) begin
                n_bad++;
                if (n_bad <= 40)
                    $display("FAIL %s: got st=%0d g=%0d b=%0d t=%0d fb=%0d/%0b ov=%0b un=%0b sl=%0b expected st=%0d g=%0d b=%0d t=%0d fb=%0d/%0b ov=%0b un=%0b sl=%0b",
                             e_cur.tag, bus.state_o, bus.good_o, bus.bad_o, bus.total_o,
                             bus.first_bad_o, bus.first_bad_vld_o, bus.overflow_o,
                             bus.underflow_o, bus.sync_lost_o, e_cur.state, e_cur.good,
                             e_cur.bad, e_cur.total, e_cur.fb, e_cur.fbv, e_cur.ovf,
                             e_cur.unf, e_cur.lost);
            end
        end
    end

    bit pat[256];
    bit ob[10];

    task automatic run_stream(input int e1, input int e2, input string tag);
        logic rv, r, dv, d;
        step(0, 1, 0, 0, 0, 0, 0, "clear");
        step(1, 0, 10, 0, 0, 0, 0, "start_skip10");
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 1, 1'($urandom), "skip");
        for (int k = 0; k <= 256; k++) begin
            rv = (k < 256);
            r  = rv ? pat[k] : 1'b0;
            dv = (k > 0);
            d  = dv ? (pat[k-1] ^ ((k - 1) == e1 || (k - 1) == e2)) : 1'b0;
            step(0, 0, 0, rv, r, dv, d, tag);
        end
        idle();
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 2, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 1, 3, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 2, 2, 1, 3, 1, 1, 0, 1};
        tbl[7]  = '{1, 0, 5, 0, 0, 0, 0, 2, 2, 1, 3, 1, 1, 0, 1};
        tbl[8]  = '{1, 1, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        bus.start_i = 0; bus.clear_i = 0; bus.skip_i = '0;
        bus.ref_valid_i = 0; bus.ref_i = 0; bus.dut_valid_i = 0; bus.dut_i = 0;
        mdl_reset();

        // Reset held for two compared edges
        repeat (2) begin
            @(negedge clk);
            exp_q.push_back(mdl_snap("reset"));
        end
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            exp_t e;
            drive(tbl[i].st, tbl[i].cl, tbl[i].sk, tbl[i].rv, tbl[i].r, tbl[i].dv, tbl[i].d);
            e.tag = $sformatf("tbl[%0d]", i);
            e.state = tbl[i].state; e.good = tbl[i].good; e.bad = tbl[i].bad;
            e.total = tbl[i].total; e.fb = tbl[i].fb; e.fbv = tbl[i].fbv;
            e.ovf = tbl[i].ovf; e.unf = tbl[i].unf; e.lost = 1'b0;
            exp_q.push_back(e);
        end

        // Skip and match
        for (int k = 0; k < 256; k++) pat[k] = 1'($urandom);
        run_stream(-1, -1, "match");
        check("match_good", bus.good_o, 256);
        check("match_bad", bus.bad_o, 0);
        check("match_total", bus.total_o, 256);
        check("match_fbv", 32'(bus.first_bad_vld_o), 0);

        // Injected errors at compares 37 and 200
        run_stream(37, 200, "inject");
        check("inject_good", bus.good_o, 254);
        check("inject_bad", bus.bad_o, 2);
        check("inject_first_bad", bus.first_bad_o, 37);
        check("inject_fbv", 32'(bus.first_bad_vld_o), 1);

        // Overflow then drain, then underflow
        step(0, 1, 0, 0, 0, 0, 0, "clear");
        step(1, 0, 0, 0, 0, 0, 0, "start_skip0");
        for (int k = 0; k < 10; k++) begin
            ob[k] = 1'($urandom);
            step(0, 0, 0, 1, ob[k], 0, 0, "ovf_push");
        end
        idle();
        check("ovf_flag", 32'(bus.overflow_o), 1);
        check("ovf_fill", 32'(u_dut.w_fill), 8);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 1, ob[k], "ovf_drain");
        idle();
        check("drain_good", bus.good_o, 8);
        check("drain_bad", bus.bad_o, 0);
        step(0, 0, 0, 0, 0, 1, 0, "underflow");
        idle();
        check("unf_flag", 32'(bus.underflow_o), 1);
        check("unf_total", bus.total_o, 8);

        // Continuous mismatches
        step(0, 1, 0, 0, 0, 0, 0, "clear");
        step(1, 0, 0, 0, 0, 0, 0, "start_skip0");
        for (int k = 0; k < 40; k++) step(0, 0, 0, 1, 0, (k > 0), 1, "mismatch");
        idle();
`ifdef VIT_BER_WINDOW_EN
        check("loss_flag", 32'(bus.sync_lost_o), 1);
        check("loss_state", 32'(bus.state_o), 3);
        check("loss_bad_frozen", bus.bad_o, 16);
        check("loss_total_frozen", bus.total_o, 16);
`else
        check("noloss_flag", 32'(bus.sync_lost_o), 0);
        check("noloss_state", 32'(bus.state_o), 2);
        check("noloss_bad", bus.bad_o, 39);
`endif

        // clear mid-RUN after 100 compares, then direct entry to RUN
        step(0, 1, 0, 0, 0, 0, 0, "clear");
        step(1, 0, 0, 0, 0, 0, 0, "start_skip0");
        for (int k = 0; k <= 100; k++) begin
            if (k < 100) pat[k] = 1'($urandom);
            step(0, 0, 0, (k < 100), (k < 100) ? pat[k] : 1'b0,
                 (k > 0), (k > 0) ? pat[k-1] : 1'b0, "run100");
        end
        idle();
        check("run100_total", bus.total_o, 100);
        step(0, 1, 0, 1, 1, 1, 1, "clear_mid_run");
        idle();
        check("clr_good", bus.good_o, 0);
        check("clr_total", bus.total_o, 0);
        check("clr_state", 32'(bus.state_o), 0);
        check("clr_flags", {29'd0, bus.overflow_o, bus.underflow_o, bus.first_bad_vld_o}, 0);
        check("clr_fill", 32'(u_dut.w_fill), 0);
        step(1, 0, 0, 0, 0, 0, 0, "restart_skip0");
        idle();
        check("restart_state", 32'(bus.state_o), 2);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
